axis_mem_server: RTL and testbench

- AXI-Stream memory endpoint that sits directly downstream of the handshake-to-AXI-Stream read and write adapters.
- Consumes single-beat write packets {addr, data} and address-only read request packets, and returns one read-payload beat per request, in request order.
- Stores data in a local synchronous RAM and serializes all read and write accesses through a single port.
- Used as the memory model in kernel testbenches and as the on-chip scratch memory in small builds.

---
 rtl/axis_mem_server.sv | 207 ++++++++++++++++++++
 tb/tb_axis_mem_server.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_mem_server.sv
// axis_mem_server: AXI-Stream memory endpoint. Accepts single-beat write
// packets {addr, data} and address-only read requests, serialises them onto
// one synchronous RAM port, and returns one read payload per request, in
// request order, through a small response FIFO.
module axis_mem_server #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,

    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] s_axis_wr_tdata,
    input  logic                             s_axis_wr_tvalid,
    output logic                             s_axis_wr_tready,
    input  logic                             s_axis_wr_tlast,

    input  logic [ADDR_WIDTH-1:0]            s_axis_rd_tdata,
    input  logic                             s_axis_rd_tvalid,
    output logic                             s_axis_rd_tready,
    input  logic                             s_axis_rd_tlast,

    output logic [DATA_WIDTH-1:0]            m_axis_rsp_tdata,
    output logic                             m_axis_rsp_tvalid,
    input  logic                             m_axis_rsp_tready,
    output logic                             m_axis_rsp_tlast,

    output logic                             err_oob,
    output logic [31:0]                      wr_count,
    output logic [31:0]                      rd_count
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int LIM_W = ADDR_WIDTH + 1;

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(RSP_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(RSP_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [LIM_W-1:0] DEPTH_LIM = LIM_W'(DEPTH);

    // Which kind of access won the RAM port most recently.
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    op_t                   last_op_q;
    op_t                   last_op_d;
    logic                  run_q;

    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  wr_grant;
    logic                  rd_grant;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  rd_room;

    logic [DATA_WIDTH-1:0] ram      [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      fifo_cnt_q;
    logic                  push;
    logic                  pop;

    // Every beat is a complete packet, so the incoming tlast carries nothing.
    logic                  unused_tlast;
    assign unused_tlast = s_axis_wr_tlast | s_axis_rd_tlast;

    assign wr_addr     = s_axis_wr_tdata[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    assign wr_data     = s_axis_wr_tdata[DATA_WIDTH-1:0];
    assign rd_addr     = s_axis_rd_tdata;
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_LIM;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_LIM;

    // The RAM read result lands straight in a FIFO slot at the accepting
    // edge, so no read is ever in flight outside the FIFO: occupancy is
    // simply the FIFO count.
    assign rd_room = fifo_cnt_q < CNT_FULL;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    // Holds both treadys low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Arbitration for the single RAM port; alternates under contention.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        wr_grant  = 1'b0;
        rd_grant  = 1'b0;
        last_op_d = last_op_q;
        if (run_q) begin
            if (s_axis_wr_tvalid && s_axis_rd_tvalid) begin
                if (rd_room && (last_op_q == OP_WRITE)) begin
                    rd_grant = 1'b1;
                end else begin
                    wr_grant = 1'b1;
                end
            end else if (s_axis_wr_tvalid) begin
                wr_grant = 1'b1;
            end else if (s_axis_rd_tvalid) begin
                rd_grant = rd_room;
            end else begin
                wr_grant = 1'b1;
                rd_grant = rd_room;
            end
        end
        if (s_axis_wr_tvalid && wr_grant) begin
            last_op_d = OP_WRITE;
        end else if (s_axis_rd_tvalid && rd_grant) begin
            last_op_d = OP_READ;
        end
    end

    assign s_axis_wr_tready = wr_grant;
    assign s_axis_rd_tready = rd_grant;
    assign wr_fire          = s_axis_wr_tvalid && wr_grant;
    assign rd_fire          = s_axis_rd_tvalid && rd_grant;

    // Arbiter history register; reset favours a write on first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers update with non-blocking assignments so every flop samples pre-edge values.
            last_op_q <= OP_READ;
        end else begin
            last_op_q <= last_op_d;
        end
    end

    // Storage RAM write port; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        // NOTE: RAM arrays take no reset so they map onto memory macros; contents are undefined until written.
        if (wr_fire && wr_in_range) begin
            ram[wr_addr] <= wr_data;
        end
    end

    // Registered RAM read written directly into the response FIFO tail.
    always_ff @(posedge clk) begin
        if (rd_fire) begin
            fifo_mem[wr_ptr_q] <= rd_in_range ? ram[rd_addr] : '0;
        end
    end

    assign push = rd_fire;
    assign pop  = m_axis_rsp_tvalid && m_axis_rsp_tready;

    // Response FIFO pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_ONE;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_ONE;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    assign m_axis_rsp_tdata  = fifo_mem[rd_ptr_q];
    assign m_axis_rsp_tvalid = (fifo_cnt_q != '0);
    assign m_axis_rsp_tlast  = 1'b1;

    // Access counters and the sticky out-of-range flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
            rd_count <= '0;
            err_oob  <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_count <= wr_count + 32'd1;
            end
            if (rd_fire) begin
                rd_count <= rd_count + 32'd1;
            end
            if ((wr_fire && !wr_in_range) || (rd_fire && !rd_in_range)) begin
                err_oob <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_mem_server.sv
// tb_axis_mem_server: self-checking bench for axis_mem_server. A bench-side
// memory/occupancy model predicts tready, tvalid and payloads; expected read
// data is queued at request acceptance and compared when the response shows.
module tb_axis_mem_server;

    localparam int AW        = 2;
    localparam int DW        = 64;
    localparam int RSP_DEPTH = 4;

    logic          clk;
    logic          rst_n;

    logic [AW+DW-1:0] s_axis_wr_tdata;
    logic             s_axis_wr_tvalid;
    logic             s_axis_wr_tready;
    logic [AW-1:0]    s_axis_rd_tdata;
    logic             s_axis_rd_tvalid;
    logic             s_axis_rd_tready;
    logic [DW-1:0]    m_axis_rsp_tdata;
    logic             m_axis_rsp_tvalid;
    logic             m_axis_rsp_tready;
    logic             m_axis_rsp_tlast;
    logic             err_oob;
    logic [31:0]      wr_count;
    logic [31:0]      rd_count;

    logic [AW+DW-1:0] d3_wr_tdata;
    logic             d3_wr_tvalid;
    logic             d3_wr_tready;
    logic [AW-1:0]    d3_rd_tdata;
    logic             d3_rd_tvalid;
    logic             d3_rd_tready;
    logic [DW-1:0]    d3_rsp_tdata;
    logic             d3_rsp_tvalid;
    logic             d3_rsp_tready;
    logic             d3_rsp_tlast;
    logic             d3_err_oob;
    logic [31:0]      d3_wr_count;
    logic [31:0]      d3_rd_count;

    axis_mem_server #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4), .RSP_DEPTH(RSP_DEPTH)
    ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axis_wr_tdata  (s_axis_wr_tdata),
        .s_axis_wr_tvalid (s_axis_wr_tvalid),
        .s_axis_wr_tready (s_axis_wr_tready),
        .s_axis_wr_tlast  (1'b1),
        .s_axis_rd_tdata  (s_axis_rd_tdata),
        .s_axis_rd_tvalid (s_axis_rd_tvalid),
        .s_axis_rd_tready (s_axis_rd_tready),
        .s_axis_rd_tlast  (1'b1),
        .m_axis_rsp_tdata (m_axis_rsp_tdata),
        .m_axis_rsp_tvalid(m_axis_rsp_tvalid),
        .m_axis_rsp_tready(m_axis_rsp_tready),
        .m_axis_rsp_tlast (m_axis_rsp_tlast),
        .err_oob          (err_oob),
        .wr_count         (wr_count),
        .rd_count         (rd_count)
    );

    // Second instance with a RAM smaller than the address space.
    axis_mem_server #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(3), .RSP_DEPTH(RSP_DEPTH)
    ) u_dut3 (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axis_wr_tdata  (d3_wr_tdata),
        .s_axis_wr_tvalid (d3_wr_tvalid),
        .s_axis_wr_tready (d3_wr_tready),
        .s_axis_wr_tlast  (1'b1),
        .s_axis_rd_tdata  (d3_rd_tdata),
        .s_axis_rd_tvalid (d3_rd_tvalid),
        .s_axis_rd_tready (d3_rd_tready),
        .s_axis_rd_tlast  (1'b1),
        .m_axis_rsp_tdata (d3_rsp_tdata),
        .m_axis_rsp_tvalid(d3_rsp_tvalid),
        .m_axis_rsp_tready(d3_rsp_tready),
        .m_axis_rsp_tlast (d3_rsp_tlast),
        .err_oob          (d3_err_oob),
        .wr_count         (d3_wr_count),
        .rd_count         (d3_rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        bit            wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        bit            rv;
        logic [AW-1:0] ra;
        bit            exp_w;
        bit            exp_r;
    } vec_t;

    int            checks   = 0;
    int            failures = 0;

    wr_t           wr_q [$];
    logic [AW-1:0] rd_q [$];
    logic [DW-1:0] sb   [$];
    logic [DW-1:0] model_mem [4];
    bit            m_last_wr;
    int            m_occ;
    int            m_wr_cnt;
    int            m_rd_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of the main DUT: drive at posedge+1, check at negedge,
    // advance the model, return at the next posedge+1.
    task automatic step(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input bit rv, input logic [AW-1:0] ra, input bit rsp_rdy,
                        output bit acc_w, output bit acc_r,
                        output bit dut_w, output bit dut_r);
        bit room, ew, er, pop;
        s_axis_wr_tvalid  = wv;
        s_axis_wr_tdata   = {wa, wd};
        s_axis_rd_tvalid  = rv;
        s_axis_rd_tdata   = ra;
        m_axis_rsp_tready = rsp_rdy;
        room = (m_occ < RSP_DEPTH);
        if (wv && rv) begin
            if (room && m_last_wr) {ew, er} = 2'b01;
            else                   {ew, er} = 2'b10;
        end else if (wv) begin
            {ew, er} = 2'b10;
        end else if (rv) begin
            ew = 1'b0;
            er = room;
        end else begin
            ew = 1'b1;
            er = room;
        end
        @(negedge clk);
        dut_w = s_axis_wr_tready;
        dut_r = s_axis_rd_tready;
        check("wr_tready", s_axis_wr_tready, ew);
        check("rd_tready", s_axis_rd_tready, er);
        check("rsp_tvalid", m_axis_rsp_tvalid, m_occ > 0);
        check("wr_count", wr_count, m_wr_cnt);
        check("rd_count", rd_count, m_rd_cnt);
        check("err_oob", err_oob, 0);
        if (m_occ > 0 && sb.size() > 0) begin
            check("rsp_tdata", m_axis_rsp_tdata, sb[0]);
            check("rsp_tlast", m_axis_rsp_tlast, 1);
        end
        pop = (m_occ > 0) && rsp_rdy;
        if (pop && sb.size() > 0) void'(sb.pop_front());
        acc_w = wv && ew;
        acc_r = rv && er;
        if (acc_w) begin
            model_mem[wa] = wd;
            m_wr_cnt++;
            m_last_wr = 1'b1;
        end
        if (acc_r) begin
            sb.push_back(model_mem[ra]);
            m_rd_cnt++;
            m_last_wr = 1'b0;
        end
        m_occ = m_occ + int'(acc_r) - int'(pop);
        @(posedge clk);
        #1;
    endtask

    // One clock fed from the pending write/read queues.
    task automatic cycle(input bit rsp_rdy);
        bit            aw, ar, dw, dr;
        wr_t           w;
        logic [AW-1:0] r;
        w = (wr_q.size() > 0) ? wr_q[0] : '0;
        r = (rd_q.size() > 0) ? rd_q[0] : '0;
        step(wr_q.size() > 0, w.addr, w.data, rd_q.size() > 0, r, rsp_rdy, aw, ar, dw, dr);
        if (aw) void'(wr_q.pop_front());
        if (ar) void'(rd_q.pop_front());
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((wr_q.size() > 0 || rd_q.size() > 0 || m_occ > 0) && n < max_cycles) begin
            cycle(1'b1);
            n++;
        end
        check("drain_done", (wr_q.size() > 0 || rd_q.size() > 0 || m_occ > 0), 0);
    endtask

    task automatic reset_model();
        wr_q.delete();
        rd_q.delete();
        sb.delete();
        m_occ     = 0;
        m_wr_cnt  = 0;
        m_rd_cnt  = 0;
        m_last_wr = 1'b0;
    endtask

    task automatic idle_inputs();
        s_axis_wr_tvalid  = 1'b0;
        s_axis_wr_tdata   = '0;
        s_axis_rd_tvalid  = 1'b0;
        s_axis_rd_tdata   = '0;
        m_axis_rsp_tready = 1'b0;
        d3_wr_tvalid      = 1'b0;
        d3_wr_tdata       = '0;
        d3_rd_tvalid      = 1'b0;
        d3_rd_tdata       = '0;
        d3_rsp_tready     = 1'b1;
    endtask

    task automatic d3_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok;
        ok = 1'b0;
        d3_wr_tdata  = {a, d};
        d3_wr_tvalid = 1'b1;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = d3_wr_tready;
            @(posedge clk);
            #1;
        end
        d3_wr_tvalid = 1'b0;
        check("d3_wr_accept", ok, 1);
    endtask

    task automatic d3_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        bit ok;
        ok = 1'b0;
        d3_rsp_tready = 1'b1;
        d3_rd_tdata   = a;
        d3_rd_tvalid  = 1'b1;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = d3_rd_tready;
            @(posedge clk);
            #1;
        end
        d3_rd_tvalid = 1'b0;
        check("d3_rd_accept", ok, 1);
        @(negedge clk);
        check("d3_rsp_tvalid", d3_rsp_tvalid, 1);
        check("d3_rsp_tdata", d3_rsp_tdata, exp);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [6];

    initial begin
        bit aw, ar, dw, dr;
        int base_rd;

        // Contention table: both streams valid, writes 0..2, reads held on 3.
        tbl[0] = '{1'b1, 2'd0, 64'h0000_0000_1111_0000, 1'b1, 2'd3, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 2'd1, 64'h0000_0000_1111_0001, 1'b1, 2'd3, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 2'd1, 64'h0000_0000_1111_0001, 1'b1, 2'd3, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 2'd2, 64'h0000_0000_1111_0002, 1'b1, 2'd3, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 2'd2, 64'h0000_0000_1111_0002, 1'b1, 2'd3, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 2'd0, 64'h0,                   1'b1, 2'd3, 1'b0, 1'b1};

        for (int i = 0; i < 4; i++) model_mem[i] = '0;
        reset_model();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_tready", s_axis_wr_tready, 0);
        check("rst_rd_tready", s_axis_rd_tready, 0);
        check("rst_rsp_tvalid", m_axis_rsp_tvalid, 0);
        check("rst_err_oob", err_oob, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_rd_count", rd_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Write then read-after-write on the following cycle.
        wr_q.push_back('{addr: 2'd2, data: 64'hAAAA_0000_0000_0001});
        cycle(1'b1);
        rd_q.push_back(2'd2);
        cycle(1'b1);
        cycle(1'b1);
        check("raw_wr_count", wr_count, 1);
        check("raw_rd_count", rd_count, 1);

        // Preload addr 3, then end on a read so the arbiter favours a write.
        wr_q.push_back('{addr: 2'd3, data: 64'h3333_3333_0000_0003});
        cycle(1'b1);
        rd_q.push_back(2'd3);
        drain(20);

        // Alternating grants under sustained contention.
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].rv, tbl[i].ra, 1'b1, aw, ar, dw, dr);
            check($sformatf("tbl%0d_wr_tready", i), dw, tbl[i].exp_w);
            check($sformatf("tbl%0d_rd_tready", i), dr, tbl[i].exp_r);
        end
        drain(20);
        check("alt_wr_count", wr_count, 5);
        check("alt_rd_count", rd_count, 5);

        // Fill every word with a distinct pattern.
        for (int i = 0; i < 4; i++)
            wr_q.push_back('{addr: AW'(i), data: 64'hC0DE_0000_0000_0000 | 64'(i * 7 + 1)});
        drain(20);

        // Back-pressure: only RSP_DEPTH reads fit while the sink stalls.
        base_rd = m_rd_cnt;
        for (int i = 0; i < 6; i++) rd_q.push_back(AW'(i % 4));
        for (int i = 0; i < 8; i++) cycle(1'b0);
        check("bp_accepted", rd_count, 32'(base_rd + 4));
        check("bp_rsp_tvalid", m_axis_rsp_tvalid, 1);
        drain(40);

        // Back-to-back reads at full rate.
        for (int i = 0; i < 16; i++) rd_q.push_back(AW'((i * 3) % 4));
        drain(40);

        // Reset while responses are buffered and the sink is stalled.
        rd_q.push_back(2'd1);
        rd_q.push_back(2'd2);
        for (int i = 0; i < 3; i++) cycle(1'b0);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_tvalid", m_axis_rsp_tvalid, 0);
        check("mid_rst_wr_count", wr_count, 0);
        check("mid_rst_rd_count", rd_count, 0);
        check("mid_rst_rd_tready", s_axis_rd_tready, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) cycle(1'b1);
        wr_q.push_back('{addr: 2'd1, data: 64'h5555_AAAA_5555_AAAA});
        cycle(1'b1);
        rd_q.push_back(2'd1);
        drain(20);

        // Out-of-range handling on the DEPTH=3 instance.
        d3_write(2'd0, 64'hD300_0000_0000_0000);
        d3_write(2'd1, 64'hD300_0000_0000_0001);
        d3_write(2'd2, 64'hD300_0000_0000_0002);
        check("d3_err_before", d3_err_oob, 0);
        d3_write(2'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        check("d3_err_after_wr", d3_err_oob, 1);
        d3_read(2'd3, 64'h0);
        d3_read(2'd0, 64'hD300_0000_0000_0000);
        d3_read(2'd1, 64'hD300_0000_0000_0001);
        d3_read(2'd2, 64'hD300_0000_0000_0002);
        check("d3_err_sticky", d3_err_oob, 1);
        check("d3_wr_count", d3_wr_count, 4);
        check("d3_rd_count", d3_rd_count, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
